lsb_memctrl: RTL

- Responder end of the LSB-to-memory request interface.
- Accepts one load or store request at a time from the load/store buffer and serialises it into byte accesses on the single-port, byte-wide RAM bus (little-endian).
- Returns the assembled raw load data with a one-cycle result pulse.
- Sits between the LSB and the top-level RAM/IO port.

---
 rtl/lsb_memctrl_if.sv | 23 ++
 rtl/lsb_memctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lsb_memctrl_if.sv
// Request/response bus between the load/store buffer (master) and the memory controller (slave).
interface lsb_memctrl_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  go_work;
  logic                  l_or_s;
  logic [2:0]            width;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           value_store;
  logic                  received;
  logic                  has_result;
  logic [31:0]           value_load;

  modport master (
    output go_work, l_or_s, width, address, value_store,
    input  received, has_result, value_load
  );

  modport slave (
    input  go_work, l_or_s, width, address, value_store,
    output received, has_result, value_load
  );
endinterface

// File: rtl/lsb_memctrl.sv
// Serialises one LSB load/store at a time into little-endian byte accesses on a byte-wide RAM bus.
// Optional macro MEMCTRL_IO_STALL_EN: hold off IO-region stores while the IO sink is full.
module lsb_memctrl #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_HI_BITS = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  lsb_memctrl_if.slave          lsb,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_t;

  state_t                state_r, state_nxt_s;
  logic                  received_r, received_nxt_s;
  logic                  has_result_r, has_result_nxt_s;
  logic [31:0]           value_load_r, value_load_nxt_s;
  logic                  mem_wr_r, mem_wr_nxt_s;
  logic [ADDR_WIDTH-1:0] mem_a_r, mem_a_nxt_s;
  logic [7:0]            mem_dout_r, mem_dout_nxt_s;
  logic [2:0]            iss_cnt_r, iss_cnt_nxt_s;
  logic [2:0]            cap_cnt_r, cap_cnt_nxt_s;
  logic [1:0]            pipe_r, pipe_nxt_s;
  logic [2:0]            req_w_r, req_w_nxt_s;
  logic [ADDR_WIDTH-1:0] req_addr_r, req_addr_nxt_s;
  logic [31:0]           req_val_r, req_val_nxt_s;
  logic                  width_ok_s;
  logic                  io_stall_s;

`ifdef MEMCTRL_IO_STALL_EN
  assign io_stall_s = lsb.l_or_s && (lsb.address[17:16] == IO_HI_BITS) && io_buffer_full;
`else
  logic unused_io_s;
  assign io_stall_s  = 1'b0;
  assign unused_io_s = ^{io_buffer_full, IO_HI_BITS};
`endif

  assign width_ok_s = (lsb.width == 3'd1) || (lsb.width == 3'd2) || (lsb.width == 3'd4);

  // Next-state and next-output computation for the request FSM.
  always_comb begin
    state_nxt_s      = state_r;
    received_nxt_s   = 1'b0;
    has_result_nxt_s = 1'b0;
    mem_wr_nxt_s     = 1'b0;
    value_load_nxt_s = value_load_r;
    mem_a_nxt_s      = mem_a_r;
    mem_dout_nxt_s   = mem_dout_r;
    iss_cnt_nxt_s    = iss_cnt_r;
    cap_cnt_nxt_s    = cap_cnt_r;
    pipe_nxt_s       = pipe_r;
    req_w_nxt_s      = req_w_r;
    req_addr_nxt_s   = req_addr_r;
    req_val_nxt_s    = req_val_r;

    if (!rdy_in) begin
      // Reads in flight are lost; rewinding makes the next ready edge re-issue the first missing byte.
      pipe_nxt_s = 2'b00;
      if (state_r == S_LOAD) begin
        iss_cnt_nxt_s = cap_cnt_r;
      end else begin
        iss_cnt_nxt_s = iss_cnt_r;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (lsb.go_work && !io_stall_s) begin
            received_nxt_s = 1'b1;
            req_w_nxt_s    = lsb.width;
            req_addr_nxt_s = lsb.address;
            req_val_nxt_s  = lsb.value_store;
            cap_cnt_nxt_s  = 3'd0;
            pipe_nxt_s     = 2'b00;
            if (!width_ok_s) begin
              iss_cnt_nxt_s = 3'd0;
              state_nxt_s   = S_DONE;
            end else if (!lsb.l_or_s) begin
              mem_a_nxt_s      = lsb.address;
              value_load_nxt_s = 32'd0;
              iss_cnt_nxt_s    = 3'd1;
              pipe_nxt_s       = 2'b01;
              state_nxt_s      = S_LOAD;
            end else begin
              mem_a_nxt_s    = lsb.address;
              mem_dout_nxt_s = lsb.value_store[7:0];
              mem_wr_nxt_s   = 1'b1;
              iss_cnt_nxt_s  = 3'd1;
              state_nxt_s    = S_STORE;
            end
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_LOAD: begin
          pipe_nxt_s = {pipe_r[0], 1'b0};
          if (iss_cnt_r < req_w_r) begin
            mem_a_nxt_s   = req_addr_r + ADDR_WIDTH'(iss_cnt_r);
            iss_cnt_nxt_s = iss_cnt_r + 3'd1;
            pipe_nxt_s[0] = 1'b1;
          end else begin
            iss_cnt_nxt_s = iss_cnt_r;
          end
          // pipe_r[1] marks that mem_din now holds the byte addressed two edges ago.
          if (pipe_r[1]) begin
            value_load_nxt_s[{cap_cnt_r[1:0], 3'b000} +: 8] = mem_din;
            cap_cnt_nxt_s = cap_cnt_r + 3'd1;
            if (cap_cnt_r == (req_w_r - 3'd1)) begin
              has_result_nxt_s = 1'b1;
              pipe_nxt_s       = 2'b00;
              state_nxt_s      = S_DONE;
            end else begin
              state_nxt_s = S_LOAD;
            end
          end else begin
            cap_cnt_nxt_s = cap_cnt_r;
          end
        end
        S_STORE: begin
          if (iss_cnt_r < req_w_r) begin
            mem_a_nxt_s    = req_addr_r + ADDR_WIDTH'(iss_cnt_r);
            mem_dout_nxt_s = req_val_r[{iss_cnt_r[1:0], 3'b000} +: 8];
            mem_wr_nxt_s   = 1'b1;
            iss_cnt_nxt_s  = iss_cnt_r + 3'd1;
          end else begin
            state_nxt_s = S_DONE;
          end
        end
        S_DONE: begin
          state_nxt_s = S_IDLE;
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r      <= S_IDLE;
      received_r   <= 1'b0;
      has_result_r <= 1'b0;
      value_load_r <= 32'd0;
      mem_wr_r     <= 1'b0;
      mem_a_r      <= '0;
      mem_dout_r   <= 8'd0;
      iss_cnt_r    <= 3'd0;
      cap_cnt_r    <= 3'd0;
      pipe_r       <= 2'b00;
      req_w_r      <= 3'd0;
      req_addr_r   <= '0;
      req_val_r    <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      received_r   <= received_nxt_s;
      has_result_r <= has_result_nxt_s;
      value_load_r <= value_load_nxt_s;
      mem_wr_r     <= mem_wr_nxt_s;
      mem_a_r      <= mem_a_nxt_s;
      mem_dout_r   <= mem_dout_nxt_s;
      iss_cnt_r    <= iss_cnt_nxt_s;
      cap_cnt_r    <= cap_cnt_nxt_s;
      pipe_r       <= pipe_nxt_s;
      req_w_r      <= req_w_nxt_s;
      req_addr_r   <= req_addr_nxt_s;
      req_val_r    <= req_val_nxt_s;
    end
  end

  assign lsb.received   = received_r;
  assign lsb.has_result = has_result_r;
  assign lsb.value_load = value_load_r;
  assign mem_wr         = mem_wr_r;
  assign mem_a          = mem_a_r;
  assign mem_dout       = mem_dout_r;

endmodule
